// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer: steps the sine generator's phase increment
// from start to stop with a programmable dwell. Option: SWEEP_BIDIR_EN.
module sweep_ctrl #(
    parameter int D_WIDTH     = 8,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   hold,
    input  logic [D_WIDTH-1:0]     cfg_start,
    input  logic [D_WIDTH-1:0]     cfg_stop,
    input  logic [D_WIDTH-1:0]     cfg_step,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                   cfg_loop,
    output logic                   en,
    output logic [D_WIDTH-1:0]     incr,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [D_WIDTH-1:0]     ONE_D = 1;
    localparam logic [DWELL_WIDTH-1:0] ONE_C = 1;

    state_t                 state_q, state_d;
    logic [D_WIDTH-1:0]     incr_q, incr_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic [D_WIDTH-1:0]     start_q, start_d;
    logic [D_WIDTH-1:0]     stop_q, stop_d;
    logic [D_WIDTH-1:0]     step_q, step_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic                   loop_q, loop_d;
    logic                   up_q, up_d;
    logic                   done_q, done_d;
`ifdef SWEEP_BIDIR_EN
    logic                   rev_q, rev_d;
`endif

    logic [D_WIDTH-1:0] tgt;
    logic               dir_up;
    logic               at_tgt;
    logic [D_WIDTH-1:0] nxt;

    // One step toward tgt, computed one bit wider so wrap clamps to tgt.
    function automatic logic [D_WIDTH-1:0] step_toward(
        input logic [D_WIDTH-1:0] cur,
        input logic [D_WIDTH-1:0] stp,
        input logic [D_WIDTH-1:0] lim,
        input logic               up
    );
        logic [D_WIDTH:0] sum;
        logic [D_WIDTH:0] diff;
        sum  = {1'b0, cur} + {1'b0, stp};
        diff = {1'b0, cur} - {1'b0, stp};
        if (up) begin
            step_toward = (sum > {1'b0, lim}) ? lim : sum[D_WIDTH-1:0];
        end else begin
            step_toward = (diff[D_WIDTH] || (diff[D_WIDTH-1:0] < lim))
                        ? lim : diff[D_WIDTH-1:0];
        end
    endfunction

    always_comb begin
`ifdef SWEEP_BIDIR_EN
        tgt    = rev_q ? start_q : stop_q;
        dir_up = rev_q ? ~up_q : up_q;
`else
        tgt    = stop_q;
        dir_up = up_q;
`endif
        at_tgt = (incr_q == tgt);
        nxt    = step_toward(incr_q, step_q, tgt, dir_up);
    end

    always_comb begin
        state_d = state_q;
        incr_d  = incr_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        loop_d  = loop_q;
        up_d    = up_q;
        done_d  = 1'b0;
`ifdef SWEEP_BIDIR_EN
        rev_d   = rev_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    start_d = cfg_start;
                    stop_d  = cfg_stop;
                    step_d  = (cfg_step == '0) ? ONE_D : cfg_step;
                    dwell_d = cfg_dwell;
                    loop_d  = cfg_loop;
                    up_d    = (cfg_stop >= cfg_start);
                    incr_d  = cfg_start;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SWEEP_BIDIR_EN
                    rev_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    incr_d  = '0;
                    cnt_d   = '0;
`ifdef SWEEP_BIDIR_EN
                    rev_d   = 1'b0;
`endif
                end else if (hold) begin
                    state_d = HOLD;
                end else if (cnt_q != dwell_q) begin
                    cnt_d = cnt_q + ONE_C;
                end else begin
                    cnt_d = '0;
                    if (!at_tgt) begin
                        incr_d = nxt;
                    end
`ifdef SWEEP_BIDIR_EN
                    // Turn around at stop; stop itself is not repeated.
                    else if (!rev_q && (start_q != stop_q)) begin
                        rev_d  = 1'b1;
                        incr_d = step_toward(incr_q, step_q, start_q, ~up_q);
                    end
`endif
                    else begin
                        done_d = 1'b1;
`ifdef SWEEP_BIDIR_EN
                        rev_d  = 1'b0;
`endif
                        if (loop_q) begin
                            incr_d = start_q;
                        end else begin
                            state_d = IDLE;
                            incr_d  = '0;
                        end
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    incr_d  = '0;
                    cnt_d   = '0;
`ifdef SWEEP_BIDIR_EN
                    rev_d   = 1'b0;
`endif
                end else if (!hold) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                incr_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            incr_q  <= '0;
            cnt_q   <= '0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            loop_q  <= 1'b0;
            up_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef SWEEP_BIDIR_EN
            rev_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            incr_q  <= incr_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            loop_q  <= loop_d;
            up_q    <= up_d;
            done_q  <= done_d;
`ifdef SWEEP_BIDIR_EN
            rev_q   <= rev_d;
`endif
        end
    end

    assign en   = (state_q == RUN);
    assign busy = (state_q != IDLE);
    assign incr = incr_q;
    assign done = done_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Scoreboard bench for sweep_ctrl: stimulus queues expected increments,
// a negedge monitor compares every cycle.
module tb_sweep_ctrl;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort, hold, cfg_loop;
    logic [DW-1:0] cfg_start, cfg_stop, cfg_step;
    logic [CW-1:0] cfg_dwell;
    logic          en, busy, done;
    logic [DW-1:0] incr;

    always #5 clk = ~clk;

    sweep_ctrl #(.D_WIDTH(DW), .DWELL_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
        .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop),
        .en(en), .incr(incr), .busy(busy), .done(done)
    );

    typedef struct {
        logic [DW-1:0] val;
        bit            last;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    bit m_active = 0;
    bit m_held   = 0;
    bit m_done   = 0;
    bit m_loop   = 0;

    task automatic check(input string nm, input logic [10:0] act,
                         input logic [10:0] expv);
        n_tot++;
        if (act === expv) n_pass++;
        else $display("FAIL %s t=%0t: got done=%0b busy=%0b en=%0b incr=%0d, expected done=%0b busy=%0b en=%0b incr=%0d",
                      nm, $time, act[10], act[9], act[8], act[7:0],
                      expv[10], expv[9], expv[8], expv[7:0]);
    endtask

    // Reference: list of values of one pass, each repeated dwell+1 times.
    task automatic push_pass(input int s, input int e, input int st,
                             input int dw);
        int vals[$];
        int cur, stp;
        bit up;
        stp = (st == 0) ? 1 : st;
        up  = (e >= s);
        cur = s;
        vals.push_back(cur);
        while (cur != e) begin
            cur = up ? cur + stp : cur - stp;
            if (up ? (cur > e) : (cur < e)) cur = e;
            vals.push_back(cur);
        end
`ifdef SWEEP_BIDIR_EN
        while (cur != s) begin
            cur = up ? cur - stp : cur + stp;
            if (up ? (cur < s) : (cur > s)) cur = s;
            vals.push_back(cur);
        end
`endif
        foreach (vals[i]) begin
            for (int k = 0; k <= dw; k++) begin
                exp_t x;
                x.val  = 8'(vals[i]);
                x.last = (i == vals.size() - 1) && (k == dw);
                q.push_back(x);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t          e;
        logic [DW-1:0] ev;
        if (rst) begin
            check("reset", {done, busy, en, incr}, 11'd0);
            m_active = 0;
            m_held   = 0;
            m_done   = 0;
            q.delete();
        end else begin
            if (m_active && q.size() == 0) begin
                n_tot++;
                $display("FAIL scoreboard_empty t=%0t: busy=%0b incr=%0d, expected a queued value",
                         $time, busy, incr);
                m_active = 0;
            end
            ev = '0;
            if (m_active) ev = q[0].val;
            check("out", {done, busy, en, incr},
                  {m_done, m_active, m_active && !m_held, ev});
            m_done = 0;
            if (!m_active) begin
                if (start && !abort) begin
                    m_active = 1;
                    m_held   = 0;
                    m_loop   = cfg_loop;
                end
            end else if (abort) begin
                m_active = 0;
                m_held   = 0;
                q.delete();
            end else if (m_held) begin
                m_held = hold;
            end else if (hold) begin
                m_held = 1;
            end else begin
                e = q.pop_front();
                if (e.last) begin
                    m_done = 1;
                    if (!m_loop) m_active = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int s, input int e, input int st,
                         input int dw, input bit lp);
        cfg_start = 8'(s);
        cfg_stop  = 8'(e);
        cfg_step  = 8'(st);
        cfg_dwell = 16'(dw);
        cfg_loop  = lp;
        start     = 1'b1;
    endtask

    task automatic run_sweep(input int s, input int e, input int st,
                             input int dw, input bit lp,
                             input int hold_pct, input int abort_pm,
                             input int start_pct, input int stop_after);
        int cyc, len, lim;
        tick();
        issue(s, e, st, dw, lp);
        abort = 1'b0;
        hold  = 1'b0;
        len = q.size();
        push_pass(s, e, st, dw);
        len = q.size() - len;
        if (lp) repeat (3) push_pass(s, e, st, dw);
        lim = stop_after;
        if (lp && lim == 0) lim = 1 + $urandom_range(2 * len);
        tick();
        start = 1'b0;
        cyc = 0;
        while (m_active) begin
            cyc++;
            if (cyc > 5000) begin
                n_tot++;
                $display("FAIL timeout: sweep still busy after %0d cycles, expected end", cyc);
                break;
            end
            hold      = ($urandom_range(99) < hold_pct);
            abort     = ($urandom_range(999) < abort_pm);
            start     = ($urandom_range(99) < start_pct);
            cfg_start = 8'($urandom);
            cfg_stop  = 8'($urandom);
            cfg_step  = 8'($urandom);
            cfg_dwell = 16'($urandom);
            cfg_loop  = 1'($urandom);
            if (lim != 0 && cyc >= lim) abort = 1'b1;
            tick();
        end
        start = 1'b0;
        hold  = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    initial begin
        int s, e, st, dw;
        bit lp;
        rst = 1'b1;
        start = 0; abort = 0; hold = 0; cfg_loop = 0;
        cfg_start = 0; cfg_stop = 0; cfg_step = 0; cfg_dwell = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        run_sweep(10, 40, 10, 2, 0, 0, 0, 0, 0);
        run_sweep(250, 255, 4, 0, 0, 0, 0, 0, 0);
        run_sweep(40, 10, 15, 0, 0, 0, 0, 0, 0);
        run_sweep(40, 10, 0, 0, 0, 0, 0, 0, 0);
        run_sweep(20, 20, 5, 1, 0, 0, 0, 0, 0);
        run_sweep(3, 0, 200, 0, 0, 0, 0, 0, 0);
        run_sweep(5, 7, 1, 0, 1, 0, 0, 0, 11);
        run_sweep(10, 30, 10, 0, 0, 0, 0, 0, 0);

        // Hold mid-dwell, ignored start, then abort.
        issue(10, 50, 10, 3, 0);
        push_pass(10, 50, 10, 3);
        tick();
        start = 1'b0;
        repeat (2) tick();
        hold = 1'b1;
        repeat (5) tick();
        hold = 1'b0;
        repeat (2) tick();
        issue(99, 1, 1, 0, 1);
        tick();
        start = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();

        // Start together with abort in IDLE stays idle.
        issue(60, 90, 3, 0, 0);
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (2) tick();

        // Asynchronous reset mid-sweep.
        issue(10, 30, 10, 1, 0);
        push_pass(10, 30, 10, 1);
        tick();
        start = 1'b0;
        repeat (3) tick();
        #1 rst = 1'b1;
        #1 check("rst_async", {done, busy, en, incr}, 11'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 25; i++) begin
            s  = $urandom_range(255);
            e  = $urandom_range(255);
            st = ($urandom_range(3) == 0) ? $urandom_range(255)
                                          : $urandom_range(8);
            dw = $urandom_range(3);
            lp = ($urandom_range(4) == 0);
            run_sweep(s, e, st, dw, lp, 8, lp ? 0 : 2, 5, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Frequency-sweep sequencer driving the sine generator's `en` and `incr` inputs. On a `start` pulse it latches a sweep configuration and steps the phase increment from a start value to a stop value. Each value is held for a programmable dwell time. It supports hold (pause), abort and continuous looping. It sits between the register/control layer and the sine generator; only `en` and `incr` connect to the datapath.

## Interface
Parameters:
- `D_WIDTH`, 8, width of phase increment values (matches the generator's `incr`).
- `DWELL_WIDTH`, 16, width of the dwell counter.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin sweep; sampled only in IDLE.
- `abort` input 1: terminate sweep immediately.
- `hold` input 1: pause sweep while high.
- `cfg_start` input D_WIDTH: first increment value.
- `cfg_stop` input D_WIDTH: final increment value.
- `cfg_step` input D_WIDTH: step magnitude.
- `cfg_dwell` input DWELL_WIDTH: each value is held for `cfg_dwell`+1 active cycles.
- `cfg_loop` input 1: restart automatically at end of pass.
- `en` output 1: enable to the sine generator's address counter.
- `incr` output D_WIDTH: phase increment to the sine generator.
- `busy` output 1: sweep in progress (RUN or HOLD).
- `done` output 1: one-cycle pulse at end of each pass.

## Operation
- States: IDLE, RUN, HOLD.
- Reset values: state IDLE; `en`=0, `incr`=0, `busy`=0, `done`=0; dwell counter 0.
- **IDLE:**
  - `en`=0, `incr`=0.
  - `start`=1 latches all cfg_* inputs, loads `incr`=`cfg_start` and dwell counter=0, then goes to RUN.
  - cfg_* inputs are ignored outside the latch cycle.
- **Direction:** up if latched stop ≥ latched start, else down.
- **Step rules:**
  - Latched step of 0 is treated as 1.
  - Next value is computed in D_WIDTH+1 bits: incr ± step.
  - If the next value passes stop (including overflow past 2^D_WIDTH−1 or underflow below 0), it clamps to stop.
- **RUN:**
  - `en`=1, `busy`=1, dwell counter increments each cycle.
  - When counter == latched dwell, the counter clears and either:
    - if `incr` ≠ stop: `incr` takes the next value;
    - if `incr` == stop: end of pass.
- **End of pass:**
  - `cfg_loop`=0 (latched): go to IDLE, `done`=1 for one cycle.
  - `cfg_loop`=1 (latched): `done`=1 for one cycle, `incr`=start, stay in RUN.
- **HOLD:**
  - Entered from RUN when `hold`=1.
  - `en`=0; `incr` and dwell counter frozen; `busy`=1.
  - Returns to RUN on `hold`=0, resuming the remaining dwell.
- **Priorities:**
  - `abort` > `hold` > dwell advance.
  - `abort` in RUN/HOLD: next cycle IDLE, `en`=0, `incr`=0, `busy`=0, no `done`.
  - `start` while busy: ignored.
  - `start` and `abort` together in IDLE: abort wins, stays IDLE.
- **Start equals stop:** the single value dwells once, then end of pass.

## Timing
- `start` sampled high at edge N (IDLE) gives `busy`=1, `en`=1, `incr`=cfg_start in cycle N+1.
- Each value is visible on `incr` with `en`=1 for exactly `cfg_dwell`+1 cycles (excluding HOLD cycles).
- `done` is asserted the cycle after the final dwell cycle, coincident with `busy`=0 and `en`=0 (non-loop).
  - In loop mode, `done` coincides with `incr`=start of the next pass; `busy` stays 1.
- `hold` and `abort` take effect one cycle after sampling.
- All outputs are registered; no combinational path from inputs to outputs.
- Asynchronous `rst` mid-sweep forces the reset values immediately; there is no `done`.

## Configuration
- Macro: `SWEEP_BIDIR_EN`.
- Defined:
  - After the stop value's dwell, the sweep reverses toward the latched start, using the same step and clamping (clamp target = start).
  - The stop value dwells once and is not repeated.
  - End of pass occurs after the start value's return dwell.
- Undefined: unidirectional sweep only, as in Operation.

## Test plan
- **Basic up sweep:** start=10, stop=40, step=10, dwell=2; `start` at cycle 0.
  - `incr` = 10 (cycles 1–3), 20 (4–6), 30 (7–9), 40 (10–12); `en`=1 throughout.
  - Cycle 13: `done`=1, `busy`=0, `incr`=0.
- **Overflow clamp:** start=250, stop=255, step=4, dwell=0 → `incr` 250, 254, 255, then `done`.
- **Down sweep and zero step:**
  - start=40, stop=10, step=15, dwell=0 → `incr` 40, 25, 10, then `done`.
  - Same configuration with step=0 → 40, 39, …, 10 (31 values).
- **Hold/abort/ignored start:** dwell=3.
  - `hold` high for 5 cycles mid-dwell: `en`=0, `incr` frozen, then the remaining dwell completes.
  - `start` pulse while busy has no effect.
  - `abort` gives `incr`=0, `busy`=0 next cycle, and no `done`.
- **Loop mode:** `cfg_loop`=1, start=5, stop=7, step=1, dwell=0.
  - `incr` 5, 6, 7, 5, 6, 7, …; `done` pulses with each return to 5; `busy` stays 1 until `abort`.
- **Bidirectional (`SWEEP_BIDIR_EN`):** start=10, stop=30, step=10, dwell=0 → `incr` 10, 20, 30, 20, 10, then `done`.
  - With `rst` asserted mid-sweep, all outputs are 0 immediately.
